// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
package truth_table_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    // Expected truth table of a 3-input AND gate (only stim==7 yields 1).
    localparam logic [7:0] DEFAULT_AND3_MASK = 8'h80;

    // Number of input combinations for an n-input block.
    function automatic int num_vectors(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (enable) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The final settle cycle is the one where the count reads 1.
    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input combination of a small combinational block in ascending
// order, samples its result after a settle time and scores it against an
// expected truth table.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int NUM_INPUTS    = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [num_vectors(NUM_INPUTS)-1:0] EXPECTED_MASK = DEFAULT_AND3_MASK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  result_in,
    output logic [NUM_INPUTS-1:0] stim,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_INPUTS:0]   err_count,
    output logic [NUM_INPUTS-1:0] first_fail_idx,
    output logic                  sample_valid,
    output logic [NUM_INPUTS-1:0] sample_idx,
    output logic                  sample_result
);

    localparam logic [NUM_INPUTS-1:0] LAST_IDX =
        NUM_INPUTS'(num_vectors(NUM_INPUTS) - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_e                state_q,          state_d;
    logic [NUM_INPUTS-1:0] idx_q,            idx_d;
    logic [NUM_INPUTS:0]   err_count_q,      err_count_d;
    logic [NUM_INPUTS-1:0] first_fail_idx_q, first_fail_idx_d;
    logic                  done_q,           done_d;
    logic                  pass_q,           pass_d;
    logic                  sample_valid_q,   sample_valid_d;
    logic [NUM_INPUTS-1:0] sample_idx_q,     sample_idx_d;
    logic                  sample_result_q,  sample_result_d;

    logic timer_load;
    logic timer_enable;
    logic timer_expired;

    settle_timer #(
        .W (8)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .enable     (timer_enable),
        .expired    (timer_expired)
    );

    // Next-state and scoring logic for the vector walk.
    // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        err_count_d      = err_count_q;
        first_fail_idx_d = first_fail_idx_q;
        done_d           = done_q;
        pass_d           = pass_q;
        sample_valid_d   = 1'b0;
        sample_idx_d     = sample_idx_q;
        sample_result_d  = sample_result_q;
        timer_load       = 1'b0;
        timer_enable     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = SETTLE;
                    idx_d            = '0;
                    err_count_d      = '0;
                    first_fail_idx_d = '0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    timer_load       = 1'b1;
                end else if (state_q == DONE) begin
                    // Flags follow DONE by one cycle so err_count is already final.
                    done_d = 1'b1;
                    pass_d = (err_count_q == '0);
                end
            end

            SETTLE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end else begin
                    timer_enable = 1'b1;
                end
            end

            SAMPLE: begin
                sample_valid_d  = 1'b1;
                sample_idx_d    = idx_q;
                sample_result_d = result_in;
                if (result_in != EXPECTED_MASK[idx_q]) begin
                    err_count_d = err_count_q + (NUM_INPUTS + 1)'(1);
                    if (err_count_q == '0) begin
                        first_fail_idx_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + NUM_INPUTS'(1);
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            err_count_q      <= '0;
            first_fail_idx_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            sample_valid_q   <= 1'b0;
            sample_idx_q     <= '0;
            sample_result_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            err_count_q      <= err_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            sample_valid_q   <= sample_valid_d;
            sample_idx_q     <= sample_idx_d;
            sample_result_q  <= sample_result_d;
        end
    end

    // The vector index is the stimulus itself, so stim only moves on vector entry.
    assign stim           = idx_q;
    assign busy           = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign sample_valid   = sample_valid_q;
    assign sample_idx     = sample_idx_q;
    assign sample_result  = sample_result_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer: default instance plus a
// SETTLE_CYCLES=1 instance, both fed by a behavioural model of the logic block.
module tb_truth_table_sequencer;

    localparam int N     = 3;
    localparam int NVEC  = 8;
    localparam logic [7:0] MASK = 8'h80;

    typedef struct {
        logic [N-1:0] idx;
        logic         res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   sel;   // 0: default instance, 1: SETTLE_CYCLES=1 instance
    int   mode;  // 0: AND3, 1: tied 0, 2: NAND3

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic model_out(input int m, input logic [N-1:0] v);
        case (m)
            0:       return &v;
            1:       return 1'b0;
            default: return ~&v;
        endcase
    endfunction

    // Default instance signals
    logic         s0, r0, b0, dn0, p0, sv0, sr0;
    logic [N-1:0] st0, ff0, si0;
    logic [N:0]   ec0;
    // SETTLE_CYCLES=1 instance signals
    logic         s1, r1, b1, dn1, p1, sv1, sr1;
    logic [N-1:0] st1, ff1, si1;
    logic [N:0]   ec1;

    assign s0 = start && (sel == 0);
    assign s1 = start && (sel == 1);
    always_comb r0 = model_out(mode, st0);
    always_comb r1 = model_out(mode, st1);

    truth_table_sequencer dut0 (
        .clk(clk), .rst(rst), .start(s0), .result_in(r0), .stim(st0),
        .busy(b0), .done(dn0), .pass(p0), .err_count(ec0), .first_fail_idx(ff0),
        .sample_valid(sv0), .sample_idx(si0), .sample_result(sr0)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .result_in(r1), .stim(st1),
        .busy(b1), .done(dn1), .pass(p1), .err_count(ec1), .first_fail_idx(ff1),
        .sample_valid(sv1), .sample_idx(si1), .sample_result(sr1)
    );

    // Observed view of whichever instance is under test.
    logic         o_busy, o_done, o_pass, o_sv, o_sr;
    logic [N-1:0] o_stim, o_ff, o_si;
    logic [N:0]   o_ec;
    always_comb begin
        o_busy = (sel == 0) ? b0  : b1;
        o_done = (sel == 0) ? dn0 : dn1;
        o_pass = (sel == 0) ? p0  : p1;
        o_sv   = (sel == 0) ? sv0 : sv1;
        o_sr   = (sel == 0) ? sr0 : sr1;
        o_stim = (sel == 0) ? st0 : st1;
        o_ff   = (sel == 0) ? ff0 : ff1;
        o_si   = (sel == 0) ? si0 : si1;
        o_ec   = (sel == 0) ? ec0 : ec1;
    end

    // Pops one expected sample and compares it against the DUT's pulse.
    task automatic score_sample(input string name);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected sample: got idx %0d with empty scoreboard", name, o_si);
        end else begin
            e = sb_q.pop_front();
            if (o_si !== e.idx || o_sr !== e.res) begin
                n_fail++;
                $display("FAIL %s sample: got idx %0d res %0b, expected idx %0d res %0b",
                         name, o_si, o_sr, e.idx, e.res);
            end
        end
    endtask

    // Pushes the expected samples for one run of the given model.
    task automatic push_expected(input int m);
        exp_t e;
        for (int v = 0; v < NVEC; v++) begin
            e.idx = N'(v);
            e.res = model_out(m, N'(v));
            sb_q.push_back(e);
        end
    endtask

    // Full run: start at edge 0, optional stray start, scored samples, final flags.
    task automatic run_table(input string name, input int m, input int settle,
                             input int extra_start_edge);
        int exp_errs = 0;
        int exp_first = -1;
        int done_edge = -1;
        int exp_done_edge;
        int exp_stim;
        logic [N-1:0] v;

        mode = m;
        for (int i = 0; i < NVEC; i++) begin
            v = N'(i);
            if (model_out(m, v) != MASK[i]) begin
                exp_errs++;
                if (exp_first < 0) exp_first = i;
            end
        end
        exp_done_edge = 1 + NVEC * (settle + 1);
        sb_q.delete();
        push_expected(m);

        @(negedge clk) start = 1'b1;
        @(posedge clk);                       // edge 0
        @(negedge clk) start = 1'b0;
        n_checks++;
        if (o_done !== 1'b0 || o_ec !== '0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s launch: done %0b err %0d busy %0b, expected 0 0 1",
                     name, o_done, o_ec, o_busy);
        end

        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_sv) score_sample(name);
            exp_stim = e / (settle + 1);
            if (exp_stim > NVEC - 1) exp_stim = NVEC - 1;
            n_checks++;
            if (o_stim !== N'(exp_stim)) begin
                n_fail++;
                $display("FAIL %s stim at edge %0d: got %0d expected %0d", name, e, o_stim, exp_stim);
            end
            start = (e + 1 == extra_start_edge);
            if (o_done) begin
                done_edge = e;
                break;
            end
        end
        start = 1'b0;

        n_checks++;
        if (done_edge != exp_done_edge) begin
            n_fail++;
            $display("FAIL %s done edge: got %0d expected %0d", name, done_edge, exp_done_edge);
        end
        n_checks++;
        if (o_ec !== (N + 1)'(exp_errs)) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d expected %0d", name, o_ec, exp_errs);
        end
        n_checks++;
        if (o_pass !== (exp_errs == 0)) begin
            n_fail++;
            $display("FAIL %s pass: got %0b expected %0b", name, o_pass, exp_errs == 0);
        end
        if (exp_errs != 0) begin
            n_checks++;
            if (o_ff !== N'(exp_first)) begin
                n_fail++;
                $display("FAIL %s first_fail_idx: got %0d expected %0d", name, o_ff, exp_first);
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing samples: got %0d left expected 0", name, sb_q.size());
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy in done: got %0b expected 0", name, o_busy);
        end
    endtask

    // Checks every output of the observed instance against its reset value.
    task automatic check_reset_values(input string name);
        n_checks++;
        if (o_stim !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
            o_ec !== '0 || o_ff !== '0 || o_sv !== 1'b0 || o_si !== '0 || o_sr !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got stim %0d busy %0b done %0b pass %0b err %0d ff %0d sv %0b si %0d sr %0b, expected all 0",
                     name, o_stim, o_busy, o_done, o_pass, o_ec, o_ff, o_sv, o_si, o_sr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 0;
        check_reset_values("reset_dut0");
        sel = 1;
        check_reset_values("reset_dut1");
        rst = 1'b0;
        sel = 0;
        repeat (2) @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_and3();
        sel = 0;
        run_table("and3", 0, 2, -1);
    endtask

    task automatic test_tied_zero();
        sel = 0;
        run_table("tied0", 1, 2, -1);
    endtask

    task automatic test_nand();
        sel = 0;
        run_table("nand3", 2, 2, -1);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        run_table("start_while_busy", 0, 2, 5);
        repeat (3) @(negedge clk);
        run_table("restart_from_done", 0, 2, -1);
    endtask

    task automatic test_reset_mid_run();
        bit hit = 0;
        sel = 0;
        mode = 0;
        sb_q.delete();
        push_expected(0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_sv) begin
                score_sample("reset_mid_run");
                if (o_si == N'(3)) begin
                    hit = 1;
                    break;
                end
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_run wait: got no sample_idx 3 within budget, expected one");
        end
        sb_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_mid_run_outputs");
        rst = 1'b0;
        @(negedge clk);
        run_table("after_mid_reset", 0, 2, -1);
    endtask

    task automatic test_settle_one();
        sel = 1;
        run_table("settle1", 0, 1, -1);
        sel = 0;
    endtask

    initial begin
        sel   = 0;
        mode  = 0;
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_and3();
        test_tied_zero();
        test_nand();
        test_back_to_back();
        test_reset_mid_run();
        test_settle_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
